// File: rtl/status_sig_pkg.sv
// Shared definitions for the GPIO status-code transmitter.
//   DATA_OFS / CTRL_OFS : Wishbone register offsets (within an 8-byte window)
//   ENABLE / OVF / BUSY : bit positions inside the CTRL register
//   CODE_START/CODE_PASS: well-known firmware status codes
//   state_e             : transmit FSM states
package status_sig_pkg;

  localparam logic [2:0] DATA_OFS = 3'h0;
  localparam logic [2:0] CTRL_OFS = 3'h4;

  localparam int ENABLE = 10;
  localparam int OVF    = 9;
  localparam int BUSY   = 8;

  localparam logic [15:0] CODE_START = 16'hFEED;
  localparam logic [15:0] CODE_PASS  = 16'hDEAD;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/status_sig_fifo.sv
// Small synchronous FIFO that queues status codes.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop, dout  : read request and head-of-queue data
//   full/empty : occupancy flags; count : occupancy 0..DEPTH
module status_sig_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by count/pointers only,
  // so stale entries are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/status_sig_tx.sv
// Wishbone-fed status-code transmitter for mprj_io[31:16].
// Firmware writes 16-bit codes to DATA; they are queued and each is driven on
// status_o for at least HOLD_CYCLES+1 clocks so an external monitor sampling
// the pins cannot miss one.
//   wb_clk_i, rst_n        : clock, asynchronous active-low reset
//   wbs_*                  : Wishbone slave (DATA at +0x0, CTRL at +0x4)
//   status_o / status_oeb  : pin value and output enables (0 = driven)
//   busy_o                 : code in hold window or codes still queued
module status_sig_tx
  import status_sig_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          HOLD_CYCLES = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0100,
  parameter logic [15:0] RESET_CODE  = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] status_o,
  output logic [15:0] status_oeb,
  output logic        busy_o
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic             sel_hit, wb_req, data_wr, ctrl_wr;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [15:0]      fifo_head;
  logic             enable_q, ovf_q;
  logic [31:0]      rd_word;
  state_e           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]      status_d;
  logic             unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // Only bits [31:3] are decoded, giving an 8-byte window for DATA and CTRL.
  assign sel_hit = (wbs_adr_i[31:3] == BASE_ADDR[31:3]);
  // Gating with ~ack makes each held request produce a single one-cycle ack.
  assign wb_req  = wbs_cyc_i & wbs_stb_i & sel_hit & ~wbs_ack_o;
  assign data_wr = wb_req & wbs_we_i & (wbs_adr_i[2:0] == DATA_OFS);
  assign ctrl_wr = wb_req & wbs_we_i & (wbs_adr_i[2:0] == CTRL_OFS);
  // Partial writes cannot form a full 16-bit code, so they are dropped.
  assign fifo_push = data_wr & (wbs_sel_i[1:0] == 2'b11);

  assign busy_o     = (state_q == HOLD) | (fifo_count != '0);
  assign status_oeb = {16{~enable_q}};

  status_sig_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (wbs_dat_i[15:0]),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    status_d = status_o;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          status_d = fifo_head;
          hold_d   = HOLD_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      status_o <= RESET_CODE;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      status_o <= status_d;
    end
  end

  always_comb begin
    rd_word = '0;
    if (wbs_adr_i[2:0] == DATA_OFS)
      rd_word = {16'h0, status_o};
    else if (wbs_adr_i[2:0] == CTRL_OFS)
      rd_word = {21'h0, enable_q, ovf_q, busy_o, 8'(fifo_count)};
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      enable_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wbs_ack_o <= wb_req;
      if (wb_req) wbs_dat_o <= wbs_we_i ? 32'h0 : rd_word;
      // Enable is set-only from software; only reset turns the pins off.
      if (ctrl_wr && wbs_dat_i[ENABLE]) enable_q <= 1'b1;
      if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      else if (ctrl_wr && wbs_dat_i[OVF])      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_status_sig_tx.sv
module tb_status_sig_tx;
  import status_sig_pkg::*;

  localparam int          DEPTH       = 4;
  localparam int          HOLD_CYCLES = 64;
  localparam int          WINDOW      = HOLD_CYCLES + 1;
  localparam logic [31:0] BASE        = 32'h3000_0100;
  localparam logic [15:0] RESET_CODE  = 16'h0000;

  logic        wb_clk_i = 1'b0;
  logic        rst_n    = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] status_o, status_oeb;
  logic        busy_o;

  status_sig_tx #(
    .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES), .BASE_ADDR(BASE), .RESET_CODE(RESET_CODE)
  ) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .status_o(status_o), .status_oeb(status_oeb), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Codes wait in a queue; a code leaves at the first edge after it was
  // written once the previous code has been shown for WINDOW clocks.
  typedef struct { bit is_read; logic [31:0] data; } wb_exp_t;
  typedef struct { logic [15:0] code; int at_edge; } code_exp_t;

  logic [15:0] m_q[$];
  wb_exp_t     wb_q[$];
  code_exp_t   code_q[$];
  int          edge_n    = 0;
  int          next_free = 0;
  logic [15:0] m_status  = RESET_CODE;
  bit          m_en = 1'b0, m_ovf = 1'b0, m_ack = 1'b0;

  always @(posedge wb_clk_i or negedge rst_n) begin : model_p
    bit          acc, pop_now, busy_pre;
    logic [31:0] rd;
    logic [15:0] code;
    if (!rst_n) begin
      m_q.delete(); wb_q.delete(); code_q.delete();
      next_free = 0; m_status = RESET_CODE;
      m_en = 1'b0; m_ovf = 1'b0; m_ack = 1'b0;
    end else begin
      edge_n++;
      acc      = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:3] == BASE[31:3]) && !m_ack;
      busy_pre = (edge_n < next_free) || (m_q.size() != 0);
      pop_now  = (m_q.size() != 0) && (edge_n >= next_free);
      if (acc) begin
        rd = 32'h0;
        if (wbs_adr_i[2:0] == 3'h0)      rd = {16'h0, m_status};
        else if (wbs_adr_i[2:0] == 3'h4) rd = {21'h0, m_en, m_ovf, busy_pre, 8'(m_q.size())};
        wb_q.push_back('{is_read: !wbs_we_i, data: rd});
      end
      if (pop_now) begin
        code = m_q.pop_front();
        if (code != m_status) code_q.push_back('{code: code, at_edge: edge_n});
        m_status  = code;
        next_free = edge_n + WINDOW;
      end
      if (acc && wbs_we_i) begin
        if (wbs_adr_i[2:0] == 3'h0 && wbs_sel_i[1:0] == 2'b11) begin
          if (m_q.size() < DEPTH) m_q.push_back(wbs_dat_i[15:0]);
          else                    m_ovf = 1'b1;
        end else if (wbs_adr_i[2:0] == 3'h4) begin
          if (wbs_dat_i[10]) m_en  = 1'b1;
          if (wbs_dat_i[9])  m_ovf = 1'b0;
        end
      end
      m_ack = acc;
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] mon_prev = RESET_CODE;

  always @(negedge wb_clk_i or negedge rst_n) begin : monitor_p
    wb_exp_t   e;
    code_exp_t c;
    if (!rst_n) begin
      mon_prev = RESET_CODE;
    end else begin
      if (wbs_ack_o) begin
        check("ack_expected", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) begin
          e = wb_q.pop_front();
          if (e.is_read) check("wb_read_data", wbs_dat_o, e.data);
        end
      end
      if (status_o !== mon_prev) begin
        check("status_change_expected", 32'(code_q.size() != 0), 32'd1);
        if (code_q.size() != 0) begin
          c = code_q.pop_front();
          check("status_code", 32'(status_o), 32'(c.code));
          check("status_edge", 32'(edge_n), 32'(c.at_edge));
        end
        mon_prev = status_o;
      end
      check("busy_o", 32'(busy_o), 32'((edge_n + 1 < next_free) || (m_q.size() != 0)));
      check("status_oeb", 32'(status_oeb), 32'({16{~m_en}}));
    end
  end

  // ---------------- driver ----------------
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdata);
    int n = 0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    do begin @(negedge wb_clk_i); n++; end while (!wbs_ack_o && n < 8);
    check("wb_ack_seen", 32'(wbs_ack_o), 32'd1);
    rdata = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, a, d, 4'hF, unused_rd);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
    wb_xfer(1'b0, a, 32'h0, 4'hF, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main_p
    logic [31:0] v;
    int          acks;

    repeat (3) @(negedge wb_clk_i);
    check("rst_status_o",   32'(status_o),   32'(RESET_CODE));
    check("rst_status_oeb", 32'(status_oeb), 32'h0000_FFFF);
    check("rst_ack",        32'(wbs_ack_o),  32'd0);
    check("rst_busy",       32'(busy_o),     32'd0);
    #2 rst_n = 1'b1;

    // Enable pins, then FEED and DEAD back-to-back; FEED must last 65 clocks.
    wr(BASE + 32'h4, 32'h0000_0400);
    fork
      begin : measure_p
        int k = 0;
        int n = 0;
        while (status_o !== CODE_START && k < 20) begin @(negedge wb_clk_i); k++; end
        while (status_o === CODE_START && n < 200) begin @(negedge wb_clk_i); n++; end
        check("feed_hold_clocks", 32'(n), 32'(WINDOW));
      end
      begin : writes_p
        wr(BASE, {16'h0, CODE_START});
        wr(BASE, {16'h0, CODE_PASS});
      end
    join
    check("oeb_enabled", 32'(status_oeb), 32'h0);
    repeat (100) @(negedge wb_clk_i);
    check("dead_persists", 32'(status_o), 32'(CODE_PASS));

    // Six writes inside one hold window: 1 shown, 4 queued, 1 dropped.
    wr(BASE, {16'h0, CODE_START});
    for (int i = 1; i < 6; i++) wr(BASE, 32'h1000 + 32'(i));
    rd_reg(BASE + 32'h4, v);
    check("ctrl_full_ovf", v, 32'h0000_0704);
    wr(BASE + 32'h4, 32'h0000_0600);
    rd_reg(BASE + 32'h4, v);
    check("ctrl_ovf_cleared", v, 32'h0000_0504);

    // Partial byte select on DATA: acked, nothing queued.
    wb_xfer(1'b1, BASE, 32'h0000_BEEF, 4'b0001, v);
    rd_reg(BASE + 32'h4, v);
    check("partial_sel_count", v, 32'h0000_0504);
    check("partial_sel_status", 32'(status_o), 32'(CODE_START));

    // Access outside the decoded window: never acked.
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE + 32'h8; wbs_dat_i = 32'h0000_1234; wbs_sel_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 16; i++) begin @(negedge wb_clk_i); if (wbs_ack_o) acks++; end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check("unselected_no_ack", 32'(acks), 32'd0);
    rd_reg(BASE, v);
    check("data_read_in_hold", v, 32'h0000_FEED);

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          logic [3:0] s;
          s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          wb_xfer(1'b1, BASE, $urandom, s, v);
        end
        6: rd_reg(BASE, v);
        7: rd_reg(BASE + 32'h4, v);
        8: wr(BASE + 32'h4, $urandom & 32'h0000_0600);
        default: repeat ($urandom_range(0, 80)) @(negedge wb_clk_i);
      endcase
    end

    // Drain, then reset mid-hold with two entries queued.
    for (int i = 0; i < DEPTH * WINDOW + 100 && (m_q.size() != 0 || edge_n < next_free); i++)
      @(negedge wb_clk_i);
    wr(BASE, 32'h0000_1111);
    wr(BASE, 32'h0000_2222);
    wr(BASE, 32'h0000_3333);
    repeat (10) @(negedge wb_clk_i);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_status", 32'(status_o),   32'(RESET_CODE));
    check("async_rst_oeb",    32'(status_oeb), 32'h0000_FFFF);
    check("async_rst_busy",   32'(busy_o),     32'd0);
    check("async_rst_ack",    32'(wbs_ack_o),  32'd0);
    @(negedge wb_clk_i);
    #2 rst_n = 1'b1;
    rd_reg(BASE + 32'h4, v);
    check("post_rst_ctrl", v, 32'h0);

    for (int i = 0; i < DEPTH * WINDOW + 100 && (m_q.size() != 0 || edge_n < next_free); i++)
      @(negedge wb_clk_i);
    repeat (4) @(negedge wb_clk_i);
    check("codes_all_seen", 32'(code_q.size()), 32'd0);
    check("acks_all_seen",  32'(wb_q.size()),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_sig_tx.md
Name: status_sig_tx

Overview:
Transmit side of the GPIO checkbit signalling used by the Caravel DV monitors. Firmware writes 16-bit status codes (0xFEED start, 0xDEAD pass, etc.) over the user Wishbone port. The block queues them and drives each one onto mprj_io[31:16] for a guaranteed minimum number of clocks, so an external monitor cannot miss a code even when firmware writes back-to-back. It sits in user_project_wrapper beside the SHA1 core and owns io_out/io_oeb[31:16].

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
HOLD_CYCLES, 64, minimum clocks each code stays on the pins (>=1)
BASE_ADDR, 32'h3000_0100, Wishbone base address; DATA at +0x0, CTRL at +0x4
RESET_CODE, 16'h0000, value driven on status_o out of reset

Ports:
wb_clk_i  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
status_o  out  16  code driven to io_out[31:16]
status_oeb  out  16  to io_oeb[31:16]; 0 = output driven
busy_o  out  1  high while a code is inside its hold window or the FIFO is non-empty

Behaviour:
- Reset (async assert, sync release):
  - status_o=RESET_CODE, status_oeb=16'hFFFF, wbs_ack_o=0, wbs_dat_o=0, busy_o=0.
  - FIFO empty, overflow=0, enable=0, FSM=IDLE, hold counter=0.
- Address decode: a Wishbone access is selected when wbs_adr_i[31:3]==BASE_ADDR[31:3]. Unselected accesses get no ack.
- Wishbone protocol:
  - A selected cyc&stb with ack low sets ack=1 for exactly one cycle; ack then returns to 0.
  - Side effects and wbs_dat_o take effect on that same edge.
- DATA write (+0x0): pushes wbs_dat_i[15:0] only if wbs_sel_i[1:0]==2'b11; otherwise ignored but still acked.
- DATA read (+0x0): returns {16'h0, status_o}.
- CTRL read (+0x4): returns {21'h0, enable, overflow, busy, count[7:0]}, where count is FIFO occupancy (0..DEPTH).
- CTRL write (+0x4): bit10 sets enable. Writing bit9=1 clears overflow (write-1-to-clear).
- Output enable: status_oeb = {16{~enable}}. The FSM runs regardless of enable.
- FIFO full:
  - A push while full and without a same-cycle pop is dropped and sets overflow (sticky).
  - A push and pop in the same cycle are both accepted; count is unchanged.
- FSM:
  - IDLE: if FIFO non-empty, pop; status_o<=head entry; counter<=HOLD_CYCLES-1; go to HOLD. Otherwise stay; status_o keeps its last value.
  - HOLD: if counter==0, go to IDLE; else counter<=counter-1.
- Latency and hold timing:
  - A code written on ack-edge N appears on status_o at edge N+1 when the FSM is IDLE.
  - Each popped code is stable for exactly HOLD_CYCLES+1 clocks before the next code can replace it: the HOLD_CYCLES hold window plus the one IDLE cycle that pops the next entry.
- The last code persists indefinitely after the FIFO drains; there is no return to RESET_CODE.
- busy_o = (state==HOLD) | (count!=0).
- Reset mid-HOLD: immediate return to reset values. FIFO contents are lost.

Decomposition:
- Package status_sig_pkg:
  - DATA_OFS=3'h0 and CTRL_OFS=3'h4.
  - CTRL bit indices: ENABLE=10, OVF=9, BUSY=8.
  - Codes CODE_START=16'hFEED and CODE_PASS=16'hDEAD.
  - FSM state enum {IDLE, HOLD}.
- One sub-module, status_sig_fifo:
  - Synchronous FIFO parameterized by WIDTH=16 and DEPTH.
  - push/pop/full/empty/count, async active-low reset on the same rst_n.
  - Simultaneous push+pop when full is allowed.

Test Plan:
- Reset, no access -> status_o=0x0000, status_oeb=0xFFFF, ack=0, busy_o=0.
- Write CTRL=0x400, then DATA 0xFEED then DATA 0xDEAD back-to-back -> oeb=0x0000. status_o=0xFEED for exactly 65 clocks (HOLD_CYCLES=64), then 0xDEAD held indefinitely. Monitor sees FEED before DEAD.
- Six DATA writes with DEPTH=4 during one hold -> first code on pins, next four queued, sixth dropped. CTRL read shows count=4, overflow=1. Write CTRL 0x600 -> overflow=0, enable stays 1.
- DATA write with wbs_sel_i=4'b0001 -> acked in one cycle, count unchanged, status_o unchanged.
- Access at BASE_ADDR+0x8 -> no ack for 16 cycles, no state change. DATA read during HOLD of 0xFEED -> wbs_dat_o=0x0000FEED.
- Assert rst_n low mid-HOLD with 2 entries queued -> status_o=0x0000, oeb=0xFFFF, count=0, busy_o=0 immediately, without waiting for a clock edge.
